// File: rtl/game_sequencer.sv
// game_sequencer: top-level Space Invaders phase controller.
// Walks the game through attract, play, respawn, next-wave and game-over,
// issues the clear/ScoreClear/Enable strobes and tracks lives and wave.
// Optional macro GAME_PAUSE_EN adds a PAUSED state toggled by startPulse.
module game_sequencer #(
    parameter int TICK_DIV  = 25000000,
    parameter int PAUSE_CYC = 50000000,
    parameter int LIVES     = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startPulse,
    input  logic       shipHit,
    input  logic       invadersCleared,
    input  logic       invadersLanded,
    output logic       clear,
    output logic       ScoreClear,
    output logic       Enable,
    output logic [1:0] lives,
    output logic [3:0] wave,
    output logic [2:0] state,
    output logic       gameOver
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (PAUSE_CYC > 1) ? $clog2(PAUSE_CYC) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0] TICK_PRE   = TW'(TICK_DIV - 2);
    localparam logic [DW-1:0] DWELL_LAST = DW'(PAUSE_CYC - 1);
    localparam logic [DW-1:0] DWELL_PRE  = DW'(PAUSE_CYC - 2);
    localparam logic [1:0]    LIVES_INIT = 2'(LIVES);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_INIT     = 3'd1,
        S_PLAY     = 3'd2,
        S_RESPAWN  = 3'd3,
        S_NEXTWAVE = 3'd4,
        S_OVER     = 3'd5
`ifdef GAME_PAUSE_EN
        , S_PAUSED = 3'd6
`endif
    } state_t;

    state_t         st;
    logic [TW-1:0]  tickCnt;
    logic [DW-1:0]  dwell;

    assign state = st;

    // Phase FSM; strobes are registered one cycle ahead so they line up with
    // the state/counter values they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            st         <= S_IDLE;
            lives      <= '0;
            wave       <= '0;
            tickCnt    <= '0;
            dwell      <= '0;
            clear      <= 1'b0;
            ScoreClear <= 1'b0;
            Enable     <= 1'b0;
            gameOver   <= 1'b0;
        end else begin
            clear      <= 1'b0;
            ScoreClear <= 1'b0;
            Enable     <= 1'b0;
            case (st)
                S_IDLE: begin
                    if (startPulse) begin
                        st         <= S_INIT;
                        clear      <= 1'b1;
                        ScoreClear <= 1'b1;
                    end
                end
                S_INIT: begin
                    st      <= S_PLAY;
                    lives   <= LIVES_INIT;
                    wave    <= '0;
                    tickCnt <= '0;
                end
                S_PLAY: begin
                    tickCnt <= (tickCnt == TICK_LAST) ? '0 : tickCnt + 1'b1;
                    if (invadersLanded) begin
                        st       <= S_OVER;
                        lives    <= '0;
                        gameOver <= 1'b1;
                    end else if (shipHit) begin
                        // lives<=1 also guards against wrapping below zero
                        if (lives <= 2'd1) begin
                            lives    <= '0;
                            st       <= S_OVER;
                            gameOver <= 1'b1;
                        end else begin
                            lives <= lives - 1'b1;
                            st    <= S_RESPAWN;
                            dwell <= '0;
                        end
                    end else if (invadersCleared) begin
                        st    <= S_NEXTWAVE;
                        dwell <= '0;
                        if (wave != 4'd15)
                            wave <= wave + 1'b1;
`ifdef GAME_PAUSE_EN
                    end else if (startPulse) begin
                        st <= S_PAUSED;
`endif
                    end else begin
                        // next cycle's tick value will be TICK_LAST
                        Enable <= (tickCnt == TICK_PRE);
                    end
                end
                S_RESPAWN, S_NEXTWAVE: begin
                    if (dwell == DWELL_LAST) begin
                        st      <= S_PLAY;
                        tickCnt <= '0;
                    end else begin
                        dwell <= dwell + 1'b1;
                        clear <= (dwell == DWELL_PRE);
                    end
                end
                S_OVER: begin
                    if (startPulse) begin
                        st         <= S_INIT;
                        clear      <= 1'b1;
                        ScoreClear <= 1'b1;
                        gameOver   <= 1'b0;
                    end
                end
`ifdef GAME_PAUSE_EN
                S_PAUSED: begin
                    if (startPulse) begin
                        st      <= S_PLAY;
                        tickCnt <= '0;
                    end
                end
`endif
                default: st <= S_IDLE;
            endcase
        end
    end

endmodule
